// File: rtl/hyper_cordic_pkg.sv
// Shared definitions for the hyperbolic CORDIC sequencer: default widths,
// controller states and the built-in repeat schedule points.
package hyper_cordic_pkg;

  localparam int I_INT_WIDTH = 3;
  localparam int I_FRA_WIDTH = 12;
  localparam int IDWIDTH     = 1 + I_INT_WIDTH + I_FRA_WIDTH;

  // Shift indices that the hyperbolic iteration executes twice
  localparam int REPEAT_A = 4;
  localparam int REPEAT_B = 13;

  // 0.5 in theta's fixed-point format at the default fraction width
  localparam int HALF = 1 << (I_FRA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/hyper_shift_sched.sv
// Shift-index counter with the hyperbolic repeat flag. Starts at 1, holds
// once on each repeat point, and flags the final step of the schedule.
module hyper_shift_sched
  import hyper_cordic_pkg::*;
#(
  parameter int NITER = 16,
  parameter int SHW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_start,
  input  logic           i_advance,
  output logic [SHW-1:0] o_shift,
  output logic           o_last
);

  logic [SHW-1:0] r_shift;
  logic           r_rep;
  logic           w_is_rep_pt;
  logic           w_hold;

  // A repeat point whose flag is still clear runs its shift a second time
  assign w_is_rep_pt = (r_shift == SHW'(REPEAT_A)) || (r_shift == SHW'(REPEAT_B));
  assign w_hold      = w_is_rep_pt && !r_rep;
  assign o_last      = (r_shift == SHW'(NITER)) && !w_hold;
  assign o_shift     = r_shift;

  // Shift counter and repeat flag; the count returns to 0 after the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= {SHW{1'b0}};
      r_rep   <= 1'b0;
    end else if (i_clear) begin
      r_shift <= {SHW{1'b0}};
      r_rep   <= 1'b0;
    end else if (i_start) begin
      r_shift <= SHW'(1);
      r_rep   <= 1'b0;
    end else if (i_advance) begin
      if (o_last) begin
        r_shift <= {SHW{1'b0}};
        r_rep   <= 1'b0;
      end else if (w_hold) begin
        r_rep   <= 1'b1;
      end else begin
        r_shift <= r_shift + SHW'(1);
        r_rep   <= 1'b0;
      end
    end else begin
      r_shift <= r_shift;
      r_rep   <= r_rep;
    end
  end

endmodule

// File: rtl/hyper_cordic_seq.sv
// Iterative sequencer for the hyperbolic CORDIC datapath: accepts an angle,
// runs stage-1 range extension, then one micro-rotation per cycle, and holds
// the result valid until the consumer takes it.
module hyper_cordic_seq
  import hyper_cordic_pkg::*;
#(
  parameter int INT_WIDTH = I_INT_WIDTH,
  parameter int FRA_WIDTH = I_FRA_WIDTH,
  parameter int DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH,
  parameter int NITER     = 16,
  parameter int SHW       = $clog2(NITER + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iValid,
  input  logic signed [DWIDTH-1:0] iTheta,
  output logic                     oReady,
  input  logic                     iZSign,
  input  logic                     iClear,
  output logic                     oLoad,
  output logic                     oCompin,
  output logic                     oS1En,
  output logic                     oStep,
  output logic [SHW-1:0]           oShift,
  output logic                     oSign,
  output logic                     oValid,
  input  logic                     iReady
);

  // +/-0.5 bounds for the stage-1 bypass window, in theta's format
  localparam logic signed [DWIDTH-1:0] C_HALF_P = DWIDTH'(1 << (FRA_WIDTH - 1));
  localparam logic signed [DWIDTH-1:0] C_HALF_N = DWIDTH'(-(1 << (FRA_WIDTH - 1)));

  state_t         r_state;
  state_t         w_next;
  logic           r_compin;
  logic           w_accept;
  logic           w_in_half;
  logic [SHW-1:0] w_shift;
  logic           w_last;

  assign w_accept  = iValid && (r_state == IDLE) && !iClear;
  assign w_in_half = (iTheta >= C_HALF_N) && (iTheta < C_HALF_P);

  hyper_shift_sched #(
    .NITER (NITER),
    .SHW   (SHW)
  ) u_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (iClear),
    .i_start   (w_accept),
    .i_advance (r_state == ITER),
    .o_shift   (w_shift),
    .o_last    (w_last)
  );

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bypass decision captured once per operand, at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_compin <= 1'b0;
    end else if (iClear) begin
      r_compin <= 1'b0;
    end else if (w_accept) begin
      r_compin <= w_in_half;
    end else begin
      r_compin <= r_compin;
    end
  end

  // Next-state logic; abort overrides accept and the result handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = iValid ? PRE : IDLE;
      PRE:     w_next = ITER;
      ITER:    w_next = w_last ? DONE : ITER;
      DONE:    w_next = iReady ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
    if (iClear) begin
      w_next = IDLE;
    end else begin
      w_next = w_next;
    end
  end

  // Output decode from state; only oLoad and oSign see live inputs
  always_comb begin
    oReady  = 1'b0;
    oLoad   = 1'b0;
    oCompin = 1'b0;
    oS1En   = 1'b0;
    oStep   = 1'b0;
    oShift  = {SHW{1'b0}};
    oSign   = 1'b0;
    oValid  = 1'b0;
    case (r_state)
      IDLE: begin
        oReady = 1'b1;
        oLoad  = w_accept;
      end
      PRE: begin
        oS1En   = 1'b1;
        oCompin = r_compin;
        oSign   = iZSign;
      end
      ITER: begin
        oStep  = 1'b1;
        oShift = w_shift;
        oSign  = iZSign;
      end
      DONE: begin
        oValid = 1'b1;
      end
      default: begin
        oReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hyper_cordic_seq.sv
// Scoreboard bench for hyper_cordic_seq: the driver queues each operand with
// its expected bypass decision; a negedge monitor predicts every output from
// cycles-since-accept and an independently built shift schedule.
module tb_hyper_cordic_seq;

  localparam int NITER = 16;
  localparam int SHW   = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iValid;
  logic [15:0] iTheta;
  logic        oReady;
  logic        iZSign;
  logic        iClear;
  logic        oLoad;
  logic        oCompin;
  logic        oS1En;
  logic        oStep;
  logic [SHW-1:0] oShift;
  logic        oSign;
  logic        oValid;
  logic        iReady;

  always #5 clk = ~clk;

  hyper_cordic_seq #(
    .INT_WIDTH (3),
    .FRA_WIDTH (12),
    .DWIDTH    (16),
    .NITER     (NITER),
    .SHW       (SHW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iValid  (iValid),
    .iTheta  (iTheta),
    .oReady  (oReady),
    .iZSign  (iZSign),
    .iClear  (iClear),
    .oLoad   (oLoad),
    .oCompin (oCompin),
    .oS1En   (oS1En),
    .oStep   (oStep),
    .oShift  (oShift),
    .oSign   (oSign),
    .oValid  (oValid),
    .iReady  (iReady)
  );

  typedef struct packed {
    logic [15:0] theta;
    logic        compin;
  } txn_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   sched[$];
  int   S;
  txn_t sbq[$];
  bit   busy = 1'b0;
  int   k = 0;
  txn_t cur;
  int   n_done = 0;
  int   n_abort = 0;
  int   n_exp_done = 0;
  bit   toggle_z = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bypass when theta, as a real number, lies in [-0.5, 0.5)
  function automatic logic ref_compin(input logic [15:0] th);
    real v;
    v = real'($signed(th)) / 4096.0;
    return (v >= -0.5) && (v < 0.5);
  endfunction

  // Reference schedule: shifts 1..NITER with 4 and 13 executed twice
  function automatic void build_sched();
    sched.delete();
    for (int s = 1; s <= NITER; s++) begin
      sched.push_back(s);
      if (s == 4 || s == 13) sched.push_back(s);
    end
    S = sched.size();
  endfunction

  // z sign stimulus: random, or strictly alternating when requested
  always @(posedge clk) begin
    #1;
    iZSign = toggle_z ? ~iZSign : 1'($urandom);
  end

  // Monitor: predict all outputs from phase of the in-flight transaction
  always @(negedge clk) begin : mon
    logic e_ready, e_load, e_comp, e_s1, e_step, e_sign, e_valid;
    logic [SHW-1:0] e_shift;
    string ph;
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      e_ready = 0; e_load = 0; e_comp = 0; e_s1 = 0;
      e_step = 0; e_sign = 0; e_valid = 0; e_shift = '0;
      if (busy) k++;
      if (!busy) begin
        ph = "idle"; e_ready = 1'b1; e_load = iValid & ~iClear;
      end else if (k == 1) begin
        ph = "pre"; e_s1 = 1'b1; e_comp = cur.compin; e_sign = iZSign;
      end else if (k <= S + 1) begin
        ph = "iter"; e_step = 1'b1; e_shift = SHW'(sched[k-2]); e_sign = iZSign;
      end else begin
        ph = "done"; e_valid = 1'b1;
      end
      check(ph, {20'd0, oReady, oLoad, oCompin, oS1En, oStep, oShift, oSign, oValid},
                {20'd0, e_ready, e_load, e_comp, e_s1, e_step, e_shift, e_sign, e_valid});
      if (!busy) begin
        if (e_load) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow: accept seen with empty scoreboard at %0t", $time);
          end else begin
            cur  = sbq.pop_front();
            busy = 1'b1;
            k    = 0;
          end
        end
      end else if (iClear) begin
        busy = 1'b0;
        n_abort++;
      end else if (k >= S + 2 && iReady) begin
        busy = 1'b0;
        n_done++;
      end else if (k > S + 200) begin
        n_cmp++; n_bad++;
        $display("FAIL txn_timeout: k=%0d required handshake by %0d", k, S + 200);
        busy = 1'b0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input logic [15:0] th);
    for (int i = 0; i < 100 && !oReady; i++) wait_cycles(1);
    if (!oReady) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait: oReady=%0b required 1 within 100 cycles", oReady);
    end
    sbq.push_back('{theta: th, compin: ref_compin(th)});
    iTheta = th;
    iValid = 1'b1;
    wait_cycles(1);
    iValid = 1'b0;
    iTheta = 16'($urandom);
  endtask

  task automatic finish_txn(input int hold);
    for (int i = 0; i < 100 && !oValid; i++) wait_cycles(1);
    if (!oValid) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_wait: oValid=%0b required 1 within 100 cycles", oValid);
    end
    wait_cycles(hold);
    iReady = 1'b1;
    wait_cycles(1);
    iReady = 1'b0;
    n_exp_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sched();
    rst_n = 1'b0; iValid = 1'b0; iTheta = 16'd0;
    iClear = 1'b0; iReady = 1'b0; iZSign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {20'd0, oReady, oLoad, oCompin, oS1En, oStep, oShift, oSign, oValid},
                           {20'd0, 1'b1, 11'd0});
    rst_n = 1'b1;
    wait_cycles(1);

    // Nominal schedule and latency
    accept(16'h0400); finish_txn(0);
    // Outside bypass window, alternating z sign
    toggle_z = 1'b1;
    accept(16'h0C00); finish_txn(1);
    toggle_z = 1'b0;
    // Window boundaries
    accept(16'hF800); finish_txn(0);
    accept(16'hF7FF); finish_txn(0);
    accept(16'h07FF); finish_txn(0);
    accept(16'h0800); finish_txn(0);
    // Backpressure in DONE
    accept(16'h0200); finish_txn(10);

    // Abort on the 7th ITER cycle, then a fresh operand right away
    accept(16'h0123);
    wait_cycles(7);
    iClear = 1'b1;
    wait_cycles(1);
    iClear = 1'b0;
    accept(16'h0400); finish_txn(0);

    // Asynchronous reset between edges mid-ITER
    accept(16'h0300);
    wait_cycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {20'd0, oReady, oLoad, oCompin, oS1En, oStep, oShift, oSign, oValid},
                         {20'd0, 1'b1, 11'd0});
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    accept(16'hFC00); finish_txn(2);

    // Randomized operands and backpressure
    for (int t = 0; t < 12; t++) begin
      accept(16'($urandom));
      finish_txn(int'($urandom_range(0, 3)));
    end

    wait_cycles(3);
    check("done_count", n_done, n_exp_done);
    check("abort_count", n_abort, 1);
    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
